iq_demodulation: RTL and testbench
==================================

# iq_demodulation

Digital IQ down-converter for the Zigbee receiver chain. It sits between the ADC and the baseband filters. Each ADC sample pair (I_IF, Q_IF) is mixed with a ternary quadrature local oscillator (LO) at fs/4 to produce baseband I_BB/Q_BB. A small LO sequencer sub-module generates the cosine/sine stream, which is wired in through dedicated ports.

## Interface
Parameters:
- WIDTH, 5, signed sample width of IF inputs and BB outputs
- LO_WIDTH, 2, signed LO width; fixed, values restricted to {-1, 0, +1}

Ports:
- clk  in  1  system clock, 50 MHz; single clock domain
- resetn  in  1  reset, synchronous, active-low
- I_IF  in  WIDTH  signed in-phase IF sample from ADC
- Q_IF  in  WIDTH  signed quadrature IF sample from ADC
- ADC_rdy  in  1  one-cycle strobe: I_IF/Q_IF valid this cycle
- cosine_in  in  LO_WIDTH  signed LO cosine from sequencer
- sine_in  in  LO_WIDTH  signed LO sine from sequencer
- I_BB  out  WIDTH  signed baseband in-phase, registered
- Q_BB  out  WIDTH  signed baseband quadrature, registered
- demod_rdy  out  1  one-cycle strobe: I_BB/Q_BB updated

## Operation
- Complex multiply by e^(-jwt):
  - I_BB = I_IF*cos + Q_IF*sin
  - Q_BB = Q_IF*cos - I_IF*sin
- Intermediate width:
  - Products and sum are computed at WIDTH+2 bits.
  - The result is saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1], which is [-16, +15] for WIDTH=5.
  - In particular, negating -16 yields +15.
- Capture:
  - The computation uses I_IF, Q_IF, cosine_in and sine_in as sampled on the clock edge where ADC_rdy=1.
  - If ADC_rdy=0, I_BB and Q_BB hold their values.
- demod_rdy is high for exactly one cycle per accepted ADC_rdy strobe.
- Back-to-back strobes on consecutive cycles are each processed; demod_rdy stays high on consecutive cycles.
- LO values outside {-1, 0, +1} (i.e. -2) are treated as -1.

## Timing
- Reset (resetn=0 at posedge):
  - I_BB=0, Q_BB=0, demod_rdy=0.
  - Reset overrides a simultaneous ADC_rdy.
  - Reset applied mid-stream discards any pending sample.
- Latency is 1 cycle. If ADC_rdy=1 at edge N, then I_BB, Q_BB and demod_rdy=1 are valid after edge N+1's update, i.e. during cycle N+1.
- demod_rdy returns to 0 on the following edge unless ADC_rdy is high again.
- The nominal ADC rate is one strobe every 5 clocks (10 MHz). The block does not depend on this rate.

## Structure
- Shared package iq_pkg:
  - typedef sample_t = logic signed [4:0]
  - typedef lo_t = logic signed [1:0]
  - constant SAMPLE_DIV = 5
  - saturate function
- Sub-module lo_fsm (LO sequencer), instantiated beside iq_demodulation at the receiver level.
- lo_fsm ports:
  - clk  in  1
  - resetn  in  1  synchronous, active-low
  - cosine_out  out  2  signed cosine
  - sine_out  out  2  signed sine
- lo_fsm parameter: SAMPLE_DIV, default 5.
- lo_fsm behaviour:
  - Internal counter 0..SAMPLE_DIV-1. The phase advances when the counter wraps.
  - Four states, in cyclic order:
    - PH0: cos=+1, sin=0
    - PH1: cos=0, sin=+1
    - PH2: cos=-1, sin=0
    - PH3: cos=0, sin=-1
  - PH3 wraps to PH0.
  - Outputs are registered.
  - Reset puts lo_fsm in PH0 with counter=0: cosine_out=+1, sine_out=0.

## Test plan
- Reset: hold resetn=0 for 5 cycles with ADC_rdy=1, I_IF=7 -> I_BB=0, Q_BB=0, demod_rdy=0; lo_fsm gives cos=+1, sin=0.
- LO sequence: release reset and run 25 clocks -> (cos,sin) is (1,0) for 5 clocks, then (0,1), (-1,0), (0,-1), then (1,0).
- Mixing:
  - I_IF=7, Q_IF=-3, cos=1, sin=0, one ADC_rdy pulse -> next cycle I_BB=7, Q_BB=-3, demod_rdy=1 for 1 cycle.
  - Same samples with cos=0, sin=1 -> I_BB=-3, Q_BB=-7.
- Saturation: I_IF=-16, Q_IF=-16, cos=-1, sin=0 -> I_BB=+15, Q_BB=+15.
- Hold: ADC_rdy=0 while I_IF/Q_IF toggle randomly for 10 cycles -> I_BB/Q_BB unchanged, demod_rdy=0.
- Mid-stream reset: resetn=0 on the same edge as ADC_rdy=1 -> outputs 0, no demod_rdy pulse; the next strobe after release is processed normally.

Source files
------------

// File: rtl/iq_demodulation_pkg.sv
// iq_pkg: shared types and helpers for the IQ down-converter slice.
//   sample_t   - signed IF/BB sample (5 bits)
//   lo_t       - signed ternary LO value (2 bits, {-1,0,+1}; -2 read as -1)
//   SAMPLE_DIV - default number of clocks per LO phase
//   lo_phase_e - LO sequencer phases, in rotation order
//   saturate() - clamp an integer into a w-bit signed range
package iq_pkg;

  typedef logic signed [4:0] sample_t;
  typedef logic signed [1:0] lo_t;

  localparam int SAMPLE_DIV = 5;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } lo_phase_e;

  function automatic int saturate(input int x, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/iq_demodulation_if.sv
// iq_demodulation_if: sample bus between the ADC/LO side and the mixer.
//   I_IF, Q_IF, ADC_rdy   - IF sample pair and its one-cycle valid strobe
//   cosine_in, sine_in    - ternary LO values applied with the sample
//   I_BB, Q_BB, demod_rdy - registered baseband pair and its strobe
// master drives the samples and LO; slave is the mixer.
interface iq_demodulation_if #(
  parameter int WIDTH    = 5,
  parameter int LO_WIDTH = 2
);
  logic signed [WIDTH-1:0]    I_IF;
  logic signed [WIDTH-1:0]    Q_IF;
  logic                       ADC_rdy;
  logic signed [LO_WIDTH-1:0] cosine_in;
  logic signed [LO_WIDTH-1:0] sine_in;
  logic signed [WIDTH-1:0]    I_BB;
  logic signed [WIDTH-1:0]    Q_BB;
  logic                       demod_rdy;

  modport master (
    output I_IF, Q_IF, ADC_rdy, cosine_in, sine_in,
    input  I_BB, Q_BB, demod_rdy
  );

  modport slave (
    input  I_IF, Q_IF, ADC_rdy, cosine_in, sine_in,
    output I_BB, Q_BB, demod_rdy
  );
endinterface

// File: rtl/iq_demodulation_lo_fsm.sv
// lo_fsm: ternary fs/4 quadrature LO sequencer.
// Holds each phase for SAMPLE_DIV clocks, cycling PH0..PH3:
//   PH0 (+1,0)  PH1 (0,+1)  PH2 (-1,0)  PH3 (0,-1)   as (cos,sin)
// Ports:
//   clk        - system clock
//   resetn     - synchronous active-low reset (PH0, counter 0)
//   cosine_out - registered signed cosine
//   sine_out   - registered signed sine
module lo_fsm #(
  parameter int SAMPLE_DIV = 5
) (
  input  logic        clk,
  input  logic        resetn,
  output iq_pkg::lo_t cosine_out,
  output iq_pkg::lo_t sine_out
);
  import iq_pkg::*;

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt_q;
  lo_phase_e     phase_q;
  lo_phase_e     phase_next;
  lo_t           cos_q;
  lo_t           sin_q;

  assign phase_next = lo_phase_e'(phase_q + 2'd1);

  // Outputs are loaded with the values of the phase being entered, so
  // they change on the same edge as the phase register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q   <= '0;
      phase_q <= PH0;
      cos_q   <= 2'sd1;
      sin_q   <= 2'sd0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      phase_q <= phase_next;
      case (phase_next)
        PH0: begin cos_q <= 2'sd1;  sin_q <= 2'sd0;  end
        PH1: begin cos_q <= 2'sd0;  sin_q <= 2'sd1;  end
        PH2: begin cos_q <= -2'sd1; sin_q <= 2'sd0;  end
        PH3: begin cos_q <= 2'sd0;  sin_q <= -2'sd1; end
      endcase
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign cosine_out = cos_q;
  assign sine_out   = sin_q;

endmodule

// File: rtl/iq_demodulation.sv
// iq_demodulation: mixes an IF sample pair with a ternary quadrature LO.
//   I_BB = sat(I_IF*cos + Q_IF*sin)
//   Q_BB = sat(Q_IF*cos - I_IF*sin)
// Ports:
//   clk    - system clock
//   resetn - synchronous active-low reset (outputs and strobe to 0)
//   bus    - slave side of iq_demodulation_if (samples, LO, results)
// One cycle of latency; results hold between ADC_rdy strobes.
module iq_demodulation
  import iq_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int LO_WIDTH = 2
) (
  input  logic             clk,
  input  logic             resetn,
  iq_demodulation_if.slave bus
);

  localparam int ACC_W = WIDTH + 2;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [WIDTH-1:0] smp_t;

  // LO is ternary, so the product is a select/negate rather than a multiply.
  // Any negative code (including the unused -2) acts as -1.
  function automatic acc_t lo_mul(input smp_t s, input logic signed [LO_WIDTH-1:0] lo);
    acc_t ext;
    ext = acc_t'(s);
    if (lo == '0) return '0;
    if (lo[LO_WIDTH-1]) return -ext;
    return ext;
  endfunction

  acc_t i_acc;
  acc_t q_acc;
  smp_t i_bb_d, i_bb_q;
  smp_t q_bb_d, q_bb_q;
  logic rdy_d, rdy_q;

  always_comb begin
    i_acc  = lo_mul(bus.I_IF, bus.cosine_in) + lo_mul(bus.Q_IF, bus.sine_in);
    q_acc  = lo_mul(bus.Q_IF, bus.cosine_in) - lo_mul(bus.I_IF, bus.sine_in);
    i_bb_d = i_bb_q;
    q_bb_d = q_bb_q;
    rdy_d  = bus.ADC_rdy;
    if (bus.ADC_rdy) begin
      i_bb_d = smp_t'(saturate(int'(i_acc), WIDTH));
      q_bb_d = smp_t'(saturate(int'(q_acc), WIDTH));
    end
  end

  // Output stage: reset wins over a coincident strobe.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      i_bb_q <= '0;
      q_bb_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      i_bb_q <= i_bb_d;
      q_bb_q <= q_bb_d;
      rdy_q  <= rdy_d;
    end
  end

  assign bus.I_BB      = i_bb_q;
  assign bus.Q_BB      = q_bb_q;
  assign bus.demod_rdy = rdy_q;

endmodule

// File: tb/tb_iq_demodulation.sv
module tb_iq_demodulation;

  localparam int W   = 5;
  localparam int LW  = 2;
  localparam int DIV = 5;

  typedef struct {
    int i;
    int q;
  } exp_t;

  logic clk;
  logic resetn;
  logic signed [1:0] lo_cos;
  logic signed [1:0] lo_sin;

  iq_demodulation_if #(.WIDTH(W), .LO_WIDTH(LW)) bus ();

  iq_demodulation #(.WIDTH(W), .LO_WIDTH(LW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  lo_fsm #(.SAMPLE_DIV(DIV)) u_lo (
    .clk        (clk),
    .resetn     (resetn),
    .cosine_out (lo_cos),
    .sine_out   (lo_sin)
  );

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  // Reference model: plain integer complex mix with clamping.
  function automatic int lo_val(input int x);
    return (x == -2) ? -1 : x;
  endfunction

  function automatic int clamp(input int v);
    int hi;
    int lo;
    hi = 2 ** (W - 1) - 1;
    lo = -(2 ** (W - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Expected LO for the k-th clock after the last reset edge.
  function automatic int exp_cos(input int k);
    int ph;
    ph = (k / DIV) % 4;
    return (ph == 0) ? 1 : ((ph == 2) ? -1 : 0);
  endfunction

  function automatic int exp_sin(input int k);
    int ph;
    ph = (k / DIV) % 4;
    return (ph == 1) ? 1 : ((ph == 3) ? -1 : 0);
  endfunction

  // One clock of stimulus; a sample accepted on this edge is queued.
  task automatic drive(input bit rn, input bit rdy, input int i, input int q,
                       input int c, input int s);
    exp_t e;
    int   cv;
    int   sv;
    @(negedge clk);
    resetn        = rn;
    bus.ADC_rdy   = rdy;
    bus.I_IF      = W'(i);
    bus.Q_IF      = W'(q);
    bus.cosine_in = LW'(c);
    bus.sine_in   = LW'(s);
    @(posedge clk);
    if (rn && rdy) begin
      cv  = lo_val(c);
      sv  = lo_val(s);
      e.i = clamp(i * cv + q * sv);
      e.q = clamp(q * cv - i * sv);
      sb.push_back(e);
    end
  endtask

  function automatic int rnd_smp();
    return int'($urandom_range(0, 31)) - 16;
  endfunction

  function automatic int rnd_lo();
    return int'($urandom_range(0, 3)) - 2;
  endfunction

  // Monitor: compares every cycle, away from the active edge.
  initial begin : monitor
    bit   rst_edge;
    int   k;
    int   hold_i;
    int   hold_q;
    exp_t e;
    k      = 0;
    hold_i = 0;
    hold_q = 0;
    forever begin
      @(posedge clk);
      rst_edge = !resetn;
      @(negedge clk);
      if (rst_edge) begin
        k      = 0;
        hold_i = 0;
        hold_q = 0;
        chk("rst_I_BB", bus.I_BB, 0);
        chk("rst_Q_BB", bus.Q_BB, 0);
        chk("rst_demod_rdy", bus.demod_rdy, 0);
      end else begin
        k++;
        if (bus.demod_rdy) begin
          if (sb.size() == 0) begin
            chk("spurious_demod_rdy", bus.demod_rdy, 0);
          end else begin
            e = sb.pop_front();
            chk("I_BB", bus.I_BB, e.i);
            chk("Q_BB", bus.Q_BB, e.q);
            hold_i = e.i;
            hold_q = e.q;
          end
        end else begin
          if (sb.size() != 0) begin
            chk("missing_demod_rdy", bus.demod_rdy, 1);
            void'(sb.pop_front());
          end
          chk("hold_I_BB", bus.I_BB, hold_i);
          chk("hold_Q_BB", bus.Q_BB, hold_q);
        end
      end
      chk("lo_cos", lo_cos, exp_cos(k));
      chk("lo_sin", lo_sin, exp_sin(k));
    end
  end

  initial begin : stim
    resetn        = 1'b0;
    bus.ADC_rdy   = 1'b1;
    bus.I_IF      = 5'sd7;
    bus.Q_IF      = 5'sd0;
    bus.cosine_in = 2'sd1;
    bus.sine_in   = 2'sd0;

    // Reset held with a strobe asserted.
    for (int n = 0; n < 5; n++) drive(1'b0, 1'b1, 7, 0, 1, 0);

    // Idle run long enough to see the full LO rotation.
    for (int n = 0; n < 25; n++) drive(1'b1, 1'b0, 0, 0, 0, 0);

    // Directed mixing cases.
    drive(1'b1, 1'b1, 7, -3, 1, 0);
    drive(1'b1, 1'b0, 0, 0, 0, 0);
    drive(1'b1, 1'b1, 7, -3, 0, 1);
    drive(1'b1, 1'b0, 0, 0, 0, 0);
    drive(1'b1, 1'b1, -16, -16, -1, 0);
    drive(1'b1, 1'b0, 0, 0, 0, 0);
    drive(1'b1, 1'b1, -16, 15, 0, -1);
    drive(1'b1, 1'b1, 5, 3, -2, 0);
    drive(1'b1, 1'b1, -16, -16, 1, -2);
    drive(1'b1, 1'b0, 0, 0, 0, 0);

    // Hold: inputs toggle with no strobe.
    for (int n = 0; n < 10; n++)
      drive(1'b1, 1'b0, rnd_smp(), rnd_smp(), rnd_lo(), rnd_lo());

    // Mid-stream reset coincident with a strobe, then normal traffic.
    drive(1'b1, 1'b1, 5, 2, 1, 0);
    drive(1'b0, 1'b1, 7, 7, 1, 0);
    drive(1'b1, 1'b1, -4, 6, 0, -1);
    drive(1'b1, 1'b0, 0, 0, 0, 0);

    // Randomized traffic with nominal-rate and back-to-back strobes.
    for (int n = 0; n < 300; n++)
      drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) == 0),
            rnd_smp(), rnd_smp(), rnd_lo(), rnd_lo());

    for (int n = 0; n < 3; n++) drive(1'b1, 1'b0, 0, 0, 0, 0);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
